laser_sense_ctrl: RTL and testbench

Sequences laser-receiver sampling for the tripwire alarm. While armed, it requests conversions from the ADC conversion engine at a fixed rate and averages the first samples into a baseline. It then compares each later sample against a hysteresis threshold and raises a sticky, debounced `laser_triggered` toward the system-state controller. It sits between the ADC conversion engine and the system-state FSM, and replaces the raw comparator path.

---
 rtl/laser_sense_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_laser_sense_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_sense_ctrl.sv
// laser_sense_ctrl: paces ADC conversions, averages a calibration baseline and
// raises a sticky, debounced beam-broken flag for the tripwire alarm.
module laser_sense_ctrl #(
  parameter int SAMPLE_DIV  = 50000,
  parameter int CAL_LOG2    = 3,
  parameter int MARGIN      = 400,
  parameter int TRIP_COUNT  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_trip,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic        laser_triggered,
  output logic        calibrated,
  output logic [11:0] baseline,
  output logic        fault
);
  // state | meaning
  // IDLE  | disarmed, all outputs cleared
  // REQ   | adc_req high, waiting for ack (timeout running)
  // WAIT  | pacing delay until the next request
  // FAULT | ADC timeout or no beam at calibration; held until disarm
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FAULT} state_t;
  typedef enum logic {PH_CAL, PH_MON} phase_t;

  localparam int ACC_W  = 12 + CAL_LOG2;
  localparam int SCNT_W = CAL_LOG2 + 1;
  localparam int WAIT_W = $clog2(SAMPLE_DIV + 1);
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int TRIP_W = $clog2(TRIP_COUNT + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << CAL_LOG2) - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(ACK_TIMEOUT);
  localparam logic [TRIP_W-1:0] TRIP_MAX  = TRIP_W'(TRIP_COUNT);
  localparam logic [11:0]       MARGIN_C  = 12'(MARGIN);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic adc_req_q, adc_req_d;
  logic trig_q, trig_d;
  logic cal_q, cal_d;
  logic fault_q, fault_d;
  logic [11:0]       baseline_q, baseline_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SCNT_W-1:0] samp_q, samp_d;
  logic [TRIP_W-1:0] trip_q, trip_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [ACC_W-1:0]  sum;
  logic [11:0]       avg;
  logic [11:0]       thresh;
  logic              broken;
  logic [TRIP_W-1:0] trip_inc;
  logic              trip_done;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    adc_req_d  = adc_req_q;
    trig_d     = trig_q;
    cal_d      = cal_q;
    fault_d    = fault_q;
    baseline_d = baseline_q;
    acc_d      = acc_q;
    samp_d     = samp_q;
    trip_d     = trip_q;
    wait_d     = wait_q;
    tmo_d      = tmo_q;

    sum       = acc_q + ACC_W'(adc_data);
    avg       = sum[ACC_W-1:CAL_LOG2];
    thresh    = baseline_q - MARGIN_C;
    broken    = adc_data < thresh;
    trip_inc  = !broken ? '0 :
                (trip_q >= TRIP_MAX) ? TRIP_MAX : trip_q + TRIP_W'(1);
    trip_done = (trip_inc == TRIP_MAX);

    if (!enable) begin
      state_d    = ST_IDLE;
      phase_d    = PH_CAL;
      adc_req_d  = 1'b0;
      trig_d     = 1'b0;
      cal_d      = 1'b0;
      fault_d    = 1'b0;
      baseline_d = '0;
    end else begin
      if (clear_trip && phase_q == PH_MON &&
          (state_q == ST_REQ || state_q == ST_WAIT)) begin
        trig_d = 1'b0;
        trip_d = '0;
      end
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_REQ;
          phase_d   = PH_CAL;
          acc_d     = '0;
          samp_d    = '0;
          trip_d    = '0;
          adc_req_d = 1'b1;
          tmo_d     = TMO_LOAD;
        end
        ST_REQ: begin
          if (adc_ack) begin
            adc_req_d = 1'b0;
            wait_d    = WAIT_LOAD;
            state_d   = ST_WAIT;
            if (phase_q == PH_CAL) begin
              acc_d  = sum;
              samp_d = samp_q + SCNT_W'(1);
              if (samp_q == SCNT_LAST) begin
                baseline_d = avg;
                if (avg <= MARGIN_C) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  trig_d  = 1'b1;
                end else begin
                  cal_d   = 1'b1;
                  phase_d = PH_MON;
                end
              end
            end else begin
              // a trip completing on this sample beats a simultaneous clear
              trip_d = (clear_trip && !trip_done) ? '0 : trip_inc;
              if (trip_done) trig_d = 1'b1;
            end
          end else if (tmo_q == '0) begin
            state_d   = ST_FAULT;
            adc_req_d = 1'b0;
            fault_d   = 1'b1;
            trig_d    = 1'b1;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            state_d   = ST_REQ;
            adc_req_d = 1'b1;
            tmo_d     = TMO_LOAD;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        ST_FAULT: begin
          adc_req_d = 1'b0;
          fault_d   = 1'b1;
          trig_d    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_CAL;
      adc_req_q  <= 1'b0;
      trig_q     <= 1'b0;
      cal_q      <= 1'b0;
      fault_q    <= 1'b0;
      baseline_q <= '0;
      acc_q      <= '0;
      samp_q     <= '0;
      trip_q     <= '0;
      wait_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      adc_req_q  <= adc_req_d;
      trig_q     <= trig_d;
      cal_q      <= cal_d;
      fault_q    <= fault_d;
      baseline_q <= baseline_d;
      acc_q      <= acc_d;
      samp_q     <= samp_d;
      trip_q     <= trip_d;
      wait_q     <= wait_d;
      tmo_q      <= tmo_d;
    end
  end

  assign adc_req         = adc_req_q;
  assign laser_triggered = trig_q;
  assign calibrated      = cal_q;
  assign baseline        = baseline_q;
  assign fault           = fault_q;
endmodule

// File: tb/tb_laser_sense_ctrl.sv
// Scoreboard bench for laser_sense_ctrl: a timestamp-based reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_laser_sense_ctrl;
  localparam int SAMPLE_DIV  = 8;
  localparam int CAL_LOG2    = 3;
  localparam int MARGIN      = 400;
  localparam int TRIP_COUNT  = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int NCAL        = 1 << CAL_LOG2;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear_trip = 1'b0;
  logic        adc_ack = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_req, laser_triggered, calibrated, fault;
  logic [11:0] baseline;

  laser_sense_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV), .CAL_LOG2(CAL_LOG2), .MARGIN(MARGIN),
    .TRIP_COUNT(TRIP_COUNT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .clear_trip(clear_trip),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .laser_triggered(laser_triggered), .calibrated(calibrated),
    .baseline(baseline), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        req;
    logic        trig;
    logic        cal;
    logic [11:0] base;
    logic        flt;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // reference model: request times are tracked as absolute cycle stamps
  bit m_armed, m_fault, m_req, m_cal, m_trig, m_mon;
  int m_base, m_req_rise, m_next_req, m_sum, m_n, m_run;

  int sample_q[$];
  bit auto_ack = 0, force_ack = 0, clr_on_ack = 0, rand_clr = 0;
  bit spurious = 0, rand_dly = 0;
  int ack_dly = 3;

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
  endfunction

  task automatic model_step();
    int run0, nr;
    if (rst || !enable) begin
      m_armed = 0; m_fault = 0; m_req = 0; m_cal = 0; m_trig = 0; m_mon = 0;
      m_base = 0;
      return;
    end
    if (m_fault) return;
    if (!m_armed) begin
      m_armed = 1; m_mon = 0; m_sum = 0; m_n = 0; m_run = 0;
      m_req = 1; m_req_rise = cyc;
      return;
    end
    run0 = m_run;
    if (m_mon && clear_trip) begin
      m_trig = 0;
      m_run = 0;
    end
    if (m_req && adc_ack) begin
      m_req = 0;
      m_next_req = cyc + SAMPLE_DIV;
      if (!m_mon) begin
        m_sum += int'(adc_data);
        m_n++;
        if (m_n == NCAL) begin
          m_base = m_sum / NCAL;
          if (m_base <= MARGIN) begin
            m_fault = 1; m_trig = 1;
          end else begin
            m_cal = 1; m_mon = 1;
          end
        end
      end else begin
        if (int'(adc_data) < m_base - MARGIN)
          nr = (run0 + 1 > TRIP_COUNT) ? TRIP_COUNT : run0 + 1;
        else
          nr = 0;
        if (nr == TRIP_COUNT) begin
          m_run = nr;
          m_trig = 1;
        end else begin
          m_run = clear_trip ? 0 : nr;
        end
      end
    end else if (m_req && cyc == m_req_rise + ACK_TIMEOUT + 1) begin
      m_req = 0; m_fault = 1; m_trig = 1;
    end else if (!m_req && cyc == m_next_req) begin
      m_req = 1;
      m_req_rise = cyc;
    end
  endtask

  task automatic tick(input bit clr = 1'b0);
    @(negedge clock);
    adc_ack  = 1'b0;
    adc_data = 12'($urandom);
    if (auto_ack && m_req && cyc == m_req_rise + ack_dly && sample_q.size() > 0) begin
      adc_ack  = 1'b1;
      adc_data = 12'(sample_q.pop_front());
      if (rand_dly)
        ack_dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 17))
                                               : int'($urandom_range(1, 5));
    end else if (force_ack || (spurious && !m_req && $urandom_range(0, 7) == 0)) begin
      adc_ack = 1'b1;
    end
    clear_trip = clr || (clr_on_ack && adc_ack) ||
                 (rand_clr && $urandom_range(0, 15) == 0);
    model_step();
    exp_q.push_back(obs_t'({m_req, m_trig, m_cal, 12'(m_base), m_fault}));
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run_samples(input int max_ticks);
    int n = 0;
    while (sample_q.size() > 0 && !m_fault && n < max_ticks) begin
      tick();
      n++;
    end
    if (n >= max_ticks) begin
      total++;
      bad++;
      $display("FAIL run_budget got=%0d pending samples want=0", sample_q.size());
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {adc_req, laser_triggered, calibrated, baseline, fault};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got req=%b trig=%b cal=%b base=%0d fault=%b want req=%b trig=%b cal=%b base=%0d fault=%b",
                   cyc - 1, a.req, a.trig, a.cal, a.base, a.flt,
                   e.req, e.trig, e.cal, e.base, e.flt);
        end
      end
    end
  end

  initial begin : stim
    int rise_c, f_c, n;
    repeat (3) tick();
    chk("reset_req", adc_req, 0);
    chk("reset_trig", laser_triggered, 0);
    chk("reset_cal", calibrated, 0);
    chk("reset_base", baseline, 0);
    chk("reset_fault", fault, 0);
    rst = 1'b0;
    tick();

    enable = 1'b1;
    tick();
    chk("enable_to_req", adc_req, 1);
    auto_ack = 1;
    for (int i = 0; i < 8; i++) sample_q.push_back(3000 + i);
    run_samples(300);
    chk("cal_baseline", baseline, 3003);
    chk("cal_flag", calibrated, 1);
    chk("cal_fault", fault, 0);
    chk("cal_req_drop", adc_req, 0);

    sample_q = '{2602, 2602, 2602, 2603, 2602, 2602, 2602};
    run_samples(300);
    chk("debounce_no_trip_yet", laser_triggered, 0);
    sample_q.push_back(2602);
    run_samples(100);
    chk("debounce_trip", laser_triggered, 1);

    tick();
    tick(1'b1);
    chk("clear_trip", laser_triggered, 0);
    sample_q = '{2602, 2602, 2602};
    run_samples(200);
    chk("collision_pre", laser_triggered, 0);
    clr_on_ack = 1;
    sample_q.push_back(2602);
    run_samples(100);
    clr_on_ack = 0;
    chk("collision_trip_wins", laser_triggered, 1);

    rise_c = -1; f_c = -1; n = 0;
    while (f_c < 0 && n < 80) begin
      tick();
      if (adc_req === 1'b1 && rise_c < 0) rise_c = cyc;
      if (fault === 1'b1 && f_c < 0) f_c = cyc;
      n++;
    end
    chk("timeout_latency", f_c - rise_c, ACK_TIMEOUT + 1);
    chk("timeout_trig", laser_triggered, 1);
    tick(1'b1);
    chk("fault_clear_ignored", fault, 1);
    chk("fault_clear_trig", laser_triggered, 1);
    enable = 1'b0;
    tick();
    chk("disarm_outputs", {adc_req, laser_triggered, calibrated, baseline, fault}, 0);

    enable = 1'b1;
    for (int i = 0; i < 8; i++) sample_q.push_back(400);
    run_samples(300);
    chk("calfail_fault", fault, 1);
    chk("calfail_cal", calibrated, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) sample_q.push_back(401);
    run_samples(300);
    chk("cal401_cal", calibrated, 1);
    chk("cal401_base", baseline, 401);
    sample_q.push_back(1);
    run_samples(100);
    chk("thr_equal_not_broken", laser_triggered, 0);
    sample_q = '{0, 0, 0, 0};
    run_samples(200);
    chk("thr_one_trip", laser_triggered, 1);

    enable = 1'b0;
    tick();
    auto_ack = 0;
    enable = 1'b1;
    tick();
    chk("rearm_req", adc_req, 1);
    tick();
    enable = 1'b0;
    tick();
    chk("midreq_drop", adc_req, 0);
    force_ack = 1;
    tick();
    force_ack = 0;
    tick();
    chk("late_ack_ignored", {adc_req, laser_triggered, calibrated, baseline, fault}, 0);
    enable = 1'b1;
    tick();
    chk("rearm2_req", adc_req, 1);
    chk("rearm2_cal", calibrated, 0);
    auto_ack = 1;
    for (int i = 0; i < 8; i++) sample_q.push_back(2000);
    run_samples(300);
    chk("recal_base", baseline, 2000);

    enable = 1'b0;
    tick();
    spurious = 1; rand_clr = 1; rand_dly = 1;
    for (int it = 0; it < 40; it++) begin
      int base;
      base = int'($urandom_range(300, 3900));
      enable = 1'b1;
      for (int i = 0; i < 8; i++)
        sample_q.push_back(clip(base + int'($urandom_range(0, 20)) - 10));
      for (int i = 0; i < 16; i++)
        sample_q.push_back(clip(base - MARGIN + int'($urandom_range(0, 8)) - 5 -
                                (($urandom_range(0, 3) == 0) ? 60 : 0)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(5, 150)) tick();
      end else begin
        run_samples(3000);
        if ($urandom_range(0, 5) == 0) repeat (40) tick();
      end
      enable = 1'b0;
      sample_q.delete();
      repeat (2) tick();
    end

    repeat (3) tick();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
